// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS-style control FSM. Sequences the
// fetch/decode/execute/writeback micro-steps, waits on a memory handshake, and
// parks in a fixed-length MDU state for mult/div.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 4,
  parameter int MDU_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_eq,
  output logic                   pc_write_ne,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic                   jal,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   busy,
  output logic [3:0]             state
);
  localparam int CW = $clog2(MDU_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_CYCLES - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_MULT = 6'h18, FN_DIV = 6'h1A;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    IEXEC = 4'd10, IWB = 4'd11, JR = 4'd12, MDU = 4'd13
  } state_t;

  state_t          curState, nxtState;
  logic [5:0]      opReg;
  logic [CW-1:0]   mduCnt;
  logic [3:0]      aluCode;

  // State register; reset always lands in FETCH regardless of where we were.
  always_ff @(posedge clk) begin
    if (!reset) curState <= FETCH;
    else        curState <= nxtState;
  end

  // Opcode captured at the DECODE edge; funct only steers the DECODE dispatch,
  // so nothing downstream needs a registered copy of it.
  always_ff @(posedge clk) begin
    if (!reset)                  opReg <= '0;
    else if (curState == DECODE) opReg <= op;
  end

  // MDU down-counter: loaded on entry, stay lasts exactly MDU_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!reset)                                   mduCnt <= '0;
    else if (curState == DECODE && nxtState == MDU) mduCnt <= CNT_INIT;
    else if (curState == MDU && mduCnt != '0)     mduCnt <= mduCnt - CW'(1);
  end

  // Next-state: dispatch on live op/funct in DECODE, registered op afterwards.
  always_comb begin
    nxtState = FETCH;
    case (curState)
      FETCH:  nxtState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxtState = MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR)                          nxtState = JR;
            else if (funct == FN_MULT || funct == FN_DIV) nxtState = MDU;
            else                                          nxtState = EXEC;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxtState = IEXEC;
          OP_BEQ, OP_BNE:                   nxtState = BRANCH;
          OP_J, OP_JAL:                     nxtState = JUMP;
          default:                          nxtState = FETCH;
        endcase
      end
      MEMADR: nxtState = (opReg == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxtState = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxtState = mem_ready ? FETCH : MEMWR;
      EXEC:   nxtState = ALUWB;
      IEXEC:  nxtState = IWB;
      MDU:    nxtState = (mduCnt == '0) ? FETCH : MDU;
      default: nxtState = FETCH;
    endcase
  end

  // Output decode per state; everything forced low while reset is held.
  always_comb begin
    pc_write = 1'b0; pc_write_eq = 1'b0; pc_write_ne = 1'b0; iord = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; reg_dst = 1'b0;
    mem_to_reg = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0; jal = 1'b0;
    alu_src_b = 2'b00; pc_source = 2'b00; busy = 1'b0; aluCode = 4'd0;
    if (reset) begin
      case (curState)
        FETCH: begin
          mem_read = 1'b1; alu_src_b = 2'b01; aluCode = 4'd1;
          ir_write = mem_ready; pc_write = mem_ready;
        end
        DECODE: begin alu_src_b = 2'b11; aluCode = 4'd1; end
        MEMADR: begin
          alu_src_a = 1'b1; alu_src_b = 2'b10;
          aluCode = (opReg == OP_LW) ? 4'd6 : 4'd5;
        end
        MEMRD:  begin mem_read = 1'b1; iord = 1'b1; end
        MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
        MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
        EXEC:   begin alu_src_a = 1'b1; aluCode = 4'hF; end
        ALUWB:  begin reg_write = 1'b1; reg_dst = 1'b1; end
        IEXEC: begin
          alu_src_a = 1'b1; alu_src_b = 2'b10;
          case (opReg)
            OP_ANDI: aluCode = 4'd3;
            OP_ORI:  aluCode = 4'd2;
            OP_LUI:  aluCode = 4'd4;
            default: aluCode = 4'd1;
          endcase
        end
        IWB:    reg_write = 1'b1;
        BRANCH: begin
          alu_src_a = 1'b1; pc_source = 2'b01;
          pc_write_eq = (opReg == OP_BEQ);
          pc_write_ne = (opReg == OP_BNE);
          aluCode = (opReg == OP_BNE) ? 4'd8 : 4'd7;
        end
        JUMP: begin
          pc_write = 1'b1; pc_source = 2'b10;
          if (opReg == OP_JAL) begin
            jal = 1'b1; reg_write = 1'b1; aluCode = 4'd10;
          end else begin
            aluCode = 4'd9;
          end
        end
        JR:     begin pc_write = 1'b1; pc_source = 2'b11; end
        MDU:    busy = 1'b1;
        default: ;
      endcase
    end
    alu_op = ALUOP_WIDTH'(aluCode);
    state  = reset ? curState : 4'd0;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-instruction micro-step model. Each instruction is
// expanded into the list of cycles it must take (with chosen memory waits) and
// the DUT is compared against that list cycle by cycle. Two instances share
// stimulus: default ALUOP_WIDTH=4 and ALUOP_WIDTH=6.
module tb_multicycle_control;
  localparam int MDUC = 8;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic memReady;

  logic [11:0] st4, st6;
  logic [1:0]  srcB4, srcB6, pcSrc4, pcSrc6;
  logic [3:0]  alu4;
  logic [5:0]  alu6;
  logic        busy4, busy6;
  logic [3:0]  state4, state6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_WIDTH(4), .MDU_CYCLES(MDUC)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(memReady),
    .pc_write(st4[11]), .pc_write_eq(st4[10]), .pc_write_ne(st4[9]), .iord(st4[8]),
    .mem_read(st4[7]), .mem_write(st4[6]), .ir_write(st4[5]), .reg_dst(st4[4]),
    .mem_to_reg(st4[3]), .reg_write(st4[2]), .alu_src_a(st4[1]), .jal(st4[0]),
    .alu_src_b(srcB4), .pc_source(pcSrc4), .alu_op(alu4), .busy(busy4), .state(state4));

  multicycle_control #(.ALUOP_WIDTH(6), .MDU_CYCLES(MDUC)) dut6 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(memReady),
    .pc_write(st6[11]), .pc_write_eq(st6[10]), .pc_write_ne(st6[9]), .iord(st6[8]),
    .mem_read(st6[7]), .mem_write(st6[6]), .ir_write(st6[5]), .reg_dst(st6[4]),
    .mem_to_reg(st6[3]), .reg_write(st6[2]), .alu_src_a(st6[1]), .jal(st6[0]),
    .alu_src_b(srcB6), .pc_source(pcSrc6), .alu_op(alu6), .busy(busy6), .state(state6));

  localparam logic [11:0] S_PCW = 12'h800, S_EQ = 12'h400, S_NE = 12'h200,
    S_IORD = 12'h100, S_MRD = 12'h080, S_MWR = 12'h040, S_IRW = 12'h020,
    S_RDST = 12'h010, S_M2R = 12'h008, S_RW = 12'h004, S_SRCA = 12'h002,
    S_JAL = 12'h001;

  typedef struct packed {
    logic [3:0]  st;
    logic [11:0] stb;
    logic [1:0]  srcB;
    logic [1:0]  pcSrc;
    logic [5:0]  alu;
    logic        busy;
    logic        mr;     // mem_ready driven during this cycle
  } cyc_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] expState;  // state entered right after DECODE
    logic [5:0] expAlu;
  } vec_t;

  cyc_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] obs4();
    return {5'd0, state4, st4, srcB4, pcSrc4, 2'b00, alu4, busy4};
  endfunction
  function automatic logic [31:0] obs6();
    return {5'd0, state6, st6, srcB6, pcSrc6, alu6, busy6};
  endfunction
  function automatic logic [31:0] expw(input cyc_t e);
    return {5'd0, e.st, e.stb, e.srcB, e.pcSrc, e.alu, e.busy};
  endfunction

  function automatic cyc_t mk(input int s, input logic [11:0] b, input logic [1:0] sb,
                              input logic [1:0] ps, input int a, input bit bz, input bit m);
    cyc_t r;
    r.st = 4'(s); r.stb = b; r.srcB = sb; r.pcSrc = ps; r.alu = 6'(a);
    r.busy = bz; r.mr = m;
    return r;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycles: fw fetch waits, mw memory waits.
  task automatic buildInstr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
    bit isLw;
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back(mk(0, S_MRD, 2'b01, 2'b00, 1, 0, 0));
    q.push_back(mk(0, S_MRD | S_IRW | S_PCW, 2'b01, 2'b00, 1, 0, 1));
    q.push_back(mk(1, 12'h0, 2'b11, 2'b00, 1, 0, rb()));
    if (o == 6'h23 || o == 6'h2B) begin
      isLw = (o == 6'h23);
      q.push_back(mk(2, S_SRCA, 2'b10, 2'b00, isLw ? 6 : 5, 0, rb()));
      for (int i = 0; i <= mw; i++)
        q.push_back(mk(isLw ? 3 : 5, (isLw ? S_MRD : S_MWR) | S_IORD, 2'b00, 2'b00, 0, 0, i == mw));
      if (isLw) q.push_back(mk(4, S_RW | S_M2R, 2'b00, 2'b00, 0, 0, rb()));
    end else if (o == 6'h00) begin
      if (f == 6'h08)
        q.push_back(mk(12, S_PCW, 2'b00, 2'b11, 0, 0, rb()));
      else if (f == 6'h18 || f == 6'h1A)
        for (int i = 0; i < MDUC; i++) q.push_back(mk(13, 12'h0, 2'b00, 2'b00, 0, 1, rb()));
      else begin
        q.push_back(mk(6, S_SRCA, 2'b00, 2'b00, 15, 0, rb()));
        q.push_back(mk(7, S_RW | S_RDST, 2'b00, 2'b00, 0, 0, rb()));
      end
    end else if (o inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) begin
      q.push_back(mk(10, S_SRCA, 2'b10, 2'b00,
                     (o == 6'h08) ? 1 : (o == 6'h0C) ? 3 : (o == 6'h0D) ? 2 : 4, 0, rb()));
      q.push_back(mk(11, S_RW, 2'b00, 2'b00, 0, 0, rb()));
    end else if (o == 6'h04 || o == 6'h05) begin
      q.push_back(mk(8, S_SRCA | ((o == 6'h04) ? S_EQ : S_NE), 2'b00, 2'b01,
                     (o == 6'h04) ? 7 : 8, 0, rb()));
    end else if (o == 6'h02 || o == 6'h03) begin
      q.push_back(mk(9, S_PCW | ((o == 6'h03) ? (S_JAL | S_RW) : 12'h0), 2'b00, 2'b10,
                     (o == 6'h03) ? 10 : 9, 0, rb()));
    end
  endtask

  // Drive the cycle list; op/funct are scrambled once DECODE has been sampled.
  task automatic runQ(input logic [5:0] o, input logic [5:0] f);
    bit past = 1'b0;
    foreach (q[i]) begin
      @(negedge clk);
      memReady = q[i].mr;
      if (past) begin op = 6'($urandom); funct = 6'($urandom); end
      else begin op = o; funct = f; end
      #1;
      chk($sformatf("op%0h fn%0h cyc%0d w4", o, f, i), obs4(), expw(q[i]));
      chk($sformatf("op%0h fn%0h cyc%0d w6", o, f, i), obs6(), expw(q[i]));
      if (q[i].st == 4'd1) past = 1'b1;
    end
  endtask

  task automatic checkFetch(input string nm);
    @(negedge clk);
    memReady = 1'b0;
    #1;
    chk({nm, " back to FETCH"}, {state4, st4, busy4}, {4'd0, S_MRD, 1'b0});
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; memReady = 1'b1;
    #1;
    chk("outputs zero in reset", obs4(), 32'h0);
    @(negedge clk);
    reset = 1'b1; memReady = 1'b0;
  endtask

  vec_t vt [16];
  logic [5:0] opPool [14];
  logic [5:0] fnPool [6];

  initial begin
    vt[0]  = '{6'h23, 6'h00, 4'd2,  6'd6};
    vt[1]  = '{6'h2B, 6'h00, 4'd2,  6'd5};
    vt[2]  = '{6'h00, 6'h20, 4'd6,  6'd15};
    vt[3]  = '{6'h00, 6'h00, 4'd6,  6'd15};
    vt[4]  = '{6'h00, 6'h08, 4'd12, 6'd0};
    vt[5]  = '{6'h00, 6'h18, 4'd13, 6'd0};
    vt[6]  = '{6'h00, 6'h1A, 4'd13, 6'd0};
    vt[7]  = '{6'h08, 6'h00, 4'd10, 6'd1};
    vt[8]  = '{6'h0C, 6'h00, 4'd10, 6'd3};
    vt[9]  = '{6'h0D, 6'h00, 4'd10, 6'd2};
    vt[10] = '{6'h0F, 6'h00, 4'd10, 6'd4};
    vt[11] = '{6'h04, 6'h00, 4'd8,  6'd7};
    vt[12] = '{6'h05, 6'h00, 4'd8,  6'd8};
    vt[13] = '{6'h02, 6'h00, 4'd9,  6'd9};
    vt[14] = '{6'h03, 6'h00, 4'd9,  6'd10};
    vt[15] = '{6'h3F, 6'h00, 4'd0,  6'd1};
    opPool = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F,
               6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    fnPool = '{6'h20, 6'h22, 6'h08, 6'h18, 6'h1A, 6'h25};

    reset = 1'b0; op = 6'h0; funct = 6'h0; memReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", obs4(), 32'h0);
    chk("reset state w6", obs6(), 32'h0);
    reset = 1'b1;
    #1;
    chk("FETCH after reset", {state4, st4, srcB4, alu4}, {4'd0, S_MRD, 2'b01, 4'd1});

    // Table: dispatch target and alu_op of the first post-DECODE cycle.
    foreach (vt[i]) begin
      doReset();
      op = vt[i].op; funct = vt[i].funct; memReady = 1'b1;
      @(negedge clk);
      memReady = 1'b0;
      @(negedge clk);
      op = ~vt[i].op;
      #1;
      chk($sformatf("tbl%0d state", i), state4, vt[i].expState);
      chk($sformatf("tbl%0d alu4", i), alu4, vt[i].expAlu);
      chk($sformatf("tbl%0d alu6", i), alu6, vt[i].expAlu);
    end
    doReset();

    // lw with two memory waits: 0,1,2,3,3,3,4,0
    buildInstr(6'h23, 6'h00, 0, 2); runQ(6'h23, 6'h00); checkFetch("lw");
    // add: 0,1,6,7,0
    buildInstr(6'h00, 6'h20, 1, 0); runQ(6'h00, 6'h20); checkFetch("add");
    // full mult: busy for exactly MDUC cycles
    buildInstr(6'h00, 6'h18, 0, 0); runQ(6'h00, 6'h18); checkFetch("mult");
    // mult interrupted by reset in its third MDU cycle
    buildInstr(6'h00, 6'h18, 0, 0);
    while (q.size() > 5) void'(q.pop_back());
    runQ(6'h00, 6'h18);
    reset = 1'b0;
    #1;
    chk("reset mid-MDU outputs", obs4(), 32'h0);
    @(negedge clk);
    reset = 1'b1; memReady = 1'b0;
    #1;
    chk("after MDU reset", {state4, busy4, st4}, {4'd0, 1'b0, S_MRD});
    buildInstr(6'h00, 6'h1A, 0, 0); runQ(6'h00, 6'h1A); checkFetch("div after reset");
    // sw interrupted by reset mid memory wait
    buildInstr(6'h2B, 6'h00, 0, 3);
    while (q.size() > 4) void'(q.pop_back());
    runQ(6'h2B, 6'h00);
    doReset();
    #1;
    chk("after MEMWR reset", {state4, st4}, {4'd0, S_MRD});
    // jal: 0,1,9,0
    buildInstr(6'h03, 6'h00, 0, 0); runQ(6'h03, 6'h00); checkFetch("jal");
    // illegal opcode: 0,1,0
    buildInstr(6'h3F, 6'h00, 0, 0); runQ(6'h3F, 6'h00); checkFetch("illegal");
    // bne on both widths
    buildInstr(6'h05, 6'h00, 0, 0); runQ(6'h05, 6'h00); checkFetch("bne");

    // Random instruction stream against the micro-step model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 13)];
      f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fnPool[$urandom_range(0, 5)];
      buildInstr(o, f, $urandom_range(0, 2), $urandom_range(0, 3));
      runQ(o, f);
    end
    checkFetch("random stream end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALUOP_WIDTH, default 4: ALUOp output width; legal values >= 4.
REQ-002 SHALL have parameter MDU_CYCLES, default 8: total cycles spent in the MDU state by mult/div; legal values >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports op and funct, inputs, 6 each: instruction-register opcode and funct fields, sampled in DECODE.
REQ-006 SHALL have port mem_ready, input, 1: memory handshake; a memory access completes in a cycle where mem_ready=1.
REQ-007 SHALL have strobe outputs, 1 bit each: pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, jal.
REQ-008 SHALL have outputs alu_src_b and pc_source, 2 bits each: select fields.
REQ-009 SHALL have output alu_op, ALUOP_WIDTH bits: ALU operation code.
REQ-010 SHALL have output busy, 1 bit: high while in MDU.
REQ-011 SHALL have output state, 4 bits: current state encoding.

Function
REQ-012 SHALL implement these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, JR=12, MDU=13; codes 14-15 SHALL go to FETCH on the next edge.
REQ-013 SHALL use the same alu_op codes as the single-cycle decoder, zero-extended to ALUOP_WIDTH: R-type 0xF, ADDI/add 1, ORI 2, ANDI 3, LUI 4, SW 5, LW 6, BEQ 7, BNE 8, J 9, JAL 10, default 0.
REQ-014 SHALL, in FETCH, drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=1 and pc_source=00.
REQ-015 SHALL, in FETCH, drive ir_write=1 and pc_write=1 only in the cycle where mem_ready=1, then go to DECODE; otherwise it holds FETCH.
REQ-016 SHALL, in DECODE, drive alu_src_a=0, alu_src_b=11 and alu_op=1 (branch target).
REQ-017 SHALL, from DECODE, go to: MEMADR for op 0x23/0x2B; EXEC for op 0 with funct not in {0x08,0x18,0x1A}; JR for op 0 with funct 0x08; MDU for op 0 with funct 0x18/0x1A; IEXEC for op 0x08/0x0C/0x0D/0x0F; BRANCH for op 0x04/0x05; JUMP for op 0x02/0x03; FETCH for any other opcode (illegal op becomes a no-op).
REQ-018 SHALL, in MEMADR, drive alu_src_a=1, alu_src_b=10 and alu_op=6 (lw) or 5 (sw), then go to MEMRD (lw) or MEMWR (sw).
REQ-019 SHALL, in MEMRD, drive mem_read=1 and iord=1, holding until mem_ready=1, then go to MEMWB.
REQ-020 SHALL, in MEMWB, drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-021 SHALL, in MEMWR, drive mem_write=1 and iord=1, holding until mem_ready=1, then go to FETCH.
REQ-022 SHALL, in EXEC, drive alu_src_a=1, alu_src_b=00 and alu_op=0xF, then go to ALUWB.
REQ-023 SHALL, in ALUWB, drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-024 SHALL, in IEXEC, drive alu_src_a=1, alu_src_b=10 and alu_op per opcode (1/3/2/4), then go to IWB.
REQ-025 SHALL, in IWB, drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-026 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=00, pc_source=01, pc_write_eq=1 only for op 0x04 and pc_write_ne=1 only for op 0x05, with alu_op=7/8, then go to FETCH.
REQ-027 SHALL, in JUMP, drive pc_write=1 and pc_source=10; for op 0x03 it SHALL additionally drive jal=1 and reg_write=1 with alu_op=10 (otherwise alu_op=9); then go to FETCH.
REQ-028 SHALL, in JR, drive pc_write=1 and pc_source=11, then go to FETCH.
REQ-029 SHALL, on entering MDU, load a down-counter with MDU_CYCLES-1 (width clog2(MDU_CYCLES)).
REQ-030 SHALL, in MDU, drive busy=1 and all strobes 0, decrementing the counter each cycle and going to FETCH in the cycle after the counter reads 0, so MDU lasts exactly MDU_CYCLES cycles.
REQ-031 SHALL register op/funct in DECODE only; later changes on op/funct SHALL NOT alter the path already taken, except that alu_op/pc_write_eq/pc_write_ne selection follows the registered op.
REQ-032 SHALL drive every output not listed for a state as 0.

Reset
REQ-033 SHALL, on a rising clk edge with reset=0, enter FETCH, clear the MDU counter and clear the registered op/funct, regardless of current state (including mid-MDU or mid-memory-wait).
REQ-034 SHALL, while reset=0, force all strobes, busy and jal to 0, state to 0 and alu_op to 0; FETCH outputs SHALL begin in the first cycle after reset=1.

Verification
REQ-035 SHALL cover lw with mem_ready low 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0; reg_write=1 only in MEMWB.
REQ-036 SHALL cover add (op 0, funct 0x20): states 0,1,6,7,0; alu_op=0xF in EXEC; reg_dst=1 and reg_write=1 in ALUWB.
REQ-037 SHALL cover mult with MDU_CYCLES=8: busy high for exactly 8 cycles, then FETCH; reset=0 asserted at MDU cycle 3 SHALL give state=0 and busy=0 on the next edge.
REQ-038 SHALL cover jal (op 0x03): states 0,1,9,0; in JUMP, jal=1, reg_write=1, pc_write=1, pc_source=10 and alu_op=10.
REQ-039 SHALL cover illegal op 0x3F: states 0,1,0 with no reg_write/mem_write; and ALUOP_WIDTH=6 giving bne alu_op=6'h08.
